rx_frame_reader: RTL and testbench

Drains the rx packet ring buffer that the MAC receive stage fills, and re-emits each committed frame as an AXI4-Stream master toward the host/DMA side. It reads from the same internal memory over a synchronous read port and walks the per-frame record: header word, timestamp word, then payload words. It returns freed space to the writer through `commited_rd_address`. It sits directly downstream of the MAC receive stage and shares its clock, reset and memory.

---
 rtl/rx_frame_reader.sv | 202 ++++++++++++++++++++
 tb/tb_rx_frame_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_reader.sv
// Ring-buffer reader: walks header/timestamp/payload records and replays each
// committed frame as an AXI4-Stream master through a 2-entry output FIFO.
module rx_frame_reader #(
  parameter int unsigned AW      = 16,
  parameter logic [15:0] MAX_LEN = 16'd9600
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [AW-1:0]   rd_addr,
  input  logic [63:0]     rd_data,
  input  logic [AW-1:0]   commited_wr_address,
  output logic [AW-1:0]   commited_rd_address,
  output logic [63:0]     m_axis_tdata,
  output logic [7:0]      m_axis_tkeep,
  output logic [127:0]    m_axis_tuser,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  input  logic            m_axis_tready,
  output logic [31:0]     frames_sent,
  output logic [31:0]     frames_skipped
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TS, S_DATA, S_DRAIN, S_COMMIT, S_SKIP
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        src_q, src_d, dst_q, dst_d;
  logic [63:0]       ts_q, ts_d;
  logic [13:0]       n_q, n_d, issued_q, issued_d;
  logic              ts_pend_q, ts_pend_d;
  logic              infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0][63:0]  fdata_q, fdata_d;
  logic [1:0][7:0]   fkeep_q, fkeep_d;
  logic [1:0]        flast_q, flast_d;
  logic              wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       sent_q, sent_d, skip_q, skip_d;

  logic [15:0] hdr_len;
  logic [13:0] hdr_n;
  logic [7:0]  keep_last;
  logic [1:0]  cnt_after;
  logic        pop, push;

  assign hdr_len   = rd_data[47:32];
  assign hdr_n     = 14'(({1'b0, hdr_len} + 17'd7) >> 3);
  assign keep_last = (len_q[2:0] == 3'd0) ? 8'hFF : ((8'h01 << len_q[2:0]) - 8'h01);

  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? fdata_q[rd_idx_q] : 64'd0;
  assign m_axis_tkeep  = m_axis_tvalid ? fkeep_q[rd_idx_q] : 8'd0;
  assign m_axis_tlast  = m_axis_tvalid & flast_q[rd_idx_q];
  assign m_axis_tuser  = {32'd0, ts_q, dst_q, src_q, len_q};

  assign rd_addr             = rd_addr_q;
  assign commited_rd_address = rd_ptr_q;
  assign frames_sent         = sent_q;
  assign frames_skipped      = skip_q;

  // A read counts as issued on the edge where the memory samples rd_addr_q;
  // its word lands in the FIFO on the following edge.
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign push      = infl_q;
  assign cnt_after = cnt_q + 2'(push) - 2'(pop);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_addr_d   = rd_addr_q;
    len_d       = len_q;
    src_d       = src_q;
    dst_d       = dst_q;
    ts_d        = ts_q;
    n_d         = n_q;
    issued_d    = issued_q;
    ts_pend_d   = ts_pend_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    fdata_d     = fdata_q;
    fkeep_d     = fkeep_q;
    flast_d     = flast_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    cnt_d       = cnt_after;
    sent_d      = sent_q;
    skip_d      = skip_q;

    if (push) begin
      fdata_d[wr_idx_q] = rd_data;
      fkeep_d[wr_idx_q] = infl_last_q ? keep_last : 8'hFF;
      flast_d[wr_idx_q] = infl_last_q;
      wr_idx_d          = ~wr_idx_q;
    end
    if (pop) rd_idx_d = ~rd_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd_ptr_q != commited_wr_address) begin
          rd_addr_d = rd_ptr_q;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        rd_addr_d = rd_ptr_q + AW'(1);
        state_d   = S_TS;
      end
      // Header word is on rd_data here; the timestamp follows one cycle later.
      S_TS: begin
        len_d    = hdr_len;
        dst_d    = rd_data[23:16];
        src_d    = rd_data[7:0];
        n_d      = hdr_n;
        issued_d = 14'd0;
        if (hdr_len == 16'd0 || hdr_len > MAX_LEN) begin
          state_d = S_SKIP;
        end else begin
          rd_addr_d = rd_ptr_q + AW'(2);
          ts_pend_d = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (ts_pend_q) begin
          ts_d      = rd_data;
          ts_pend_d = 1'b0;
        end
        if (cnt_after < 2'd2) begin
          infl_d      = 1'b1;
          infl_last_d = (issued_q == n_q - 14'd1);
          issued_d    = issued_q + 14'd1;
          rd_addr_d   = rd_addr_q + AW'(1);
          if (issued_q == n_q - 14'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && flast_q[rd_idx_q]) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        rd_ptr_d = rd_ptr_q + AW'(2) + AW'(n_q);
        sent_d   = sent_q + 32'd1;
        state_d  = S_IDLE;
      end
      S_SKIP: begin
        rd_ptr_d = rd_ptr_q + AW'(2) + AW'(n_q);
        skip_d   = skip_q + 32'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      rd_addr_q   <= '0;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      ts_q        <= '0;
      n_q         <= '0;
      issued_q    <= '0;
      ts_pend_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      fdata_q     <= '0;
      fkeep_q     <= '0;
      flast_q     <= '0;
      wr_idx_q    <= 1'b0;
      rd_idx_q    <= 1'b0;
      cnt_q       <= '0;
      sent_q      <= '0;
      skip_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      ts_q        <= ts_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      ts_pend_q   <= ts_pend_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      fdata_q     <= fdata_d;
      fkeep_q     <= fkeep_d;
      flast_q     <= flast_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      skip_q      <= skip_d;
    end
  end

endmodule

// File: tb/tb_rx_frame_reader.sv
// Bench for rx_frame_reader on a 16-word ring: directed cases from the
// behaviour description, then randomized records against a beat-list model.
module tb_rx_frame_reader;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [AW-1:0]  rd_addr;
  logic [63:0]    rd_data = 64'd0;
  logic [AW-1:0]  wr_ptr = '0;
  logic [AW-1:0]  crd;
  logic [63:0]    tdata;
  logic [7:0]     tkeep;
  logic [127:0]   tuser;
  logic           tvalid, tlast;
  logic           tready = 1'b1;
  logic [31:0]    fsent, fskip;

  rx_frame_reader #(.AW(AW), .MAX_LEN(16'd9600)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .commited_wr_address(wr_ptr), .commited_rd_address(crd),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready),
    .frames_sent(fsent), .frames_skipped(fskip));

  always #5 clk = ~clk;

  logic [63:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   keep;
    logic         last;
    logic [127:0] user;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0, errors = 0;
  logic [3:0]  wb = 4'd0;
  int          exp_sent = 0, exp_skip = 0;
  int          rdy_mode = 0, bp_i = 0;
  int          beat_cnt = 0;
  bit          tput_mode = 1'b0, have_prev = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writes one record at the model's write base and queues the beats it must produce.
  task automatic put_rec(input int len, input logic [7:0] src, input logic [7:0] dst,
                         input logic [63:0] ts);
    logic [15:0]  l16 = 16'(len);
    int           n = (len + 7) / 8;
    int           rem = len % 8;
    logic [7:0]   kl = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
    logic [127:0] user = {32'd0, ts, dst, src, l16};
    logic [63:0]  w;
    beat_t        b;
    mem[wb]            = {16'd0, l16, 8'd0, dst, 8'd0, src};
    mem[4'(wb + 4'd1)] = ts;
    if (len != 0 && len <= 9600) begin
      for (int k = 0; k < n; k++) begin
        w = {$urandom, $urandom};
        mem[4'(int'(wb) + 2 + k)] = w;
        b.data = w;
        b.keep = (k == n - 1) ? kl : 8'hFF;
        b.last = (k == n - 1);
        b.user = user;
        exp_q.push_back(b);
      end
      exp_sent++;
    end else begin
      exp_skip++;
    end
    wb = 4'((int'(wb) + 2 + n) % 16);
  endtask

  task automatic commit();
    @(posedge clk);
    #1 wr_ptr = wb;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (crd !== wb && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk({tag, " rd_ptr"}, crd, wb);
    chk({tag, " frames_sent"}, fsent, exp_sent);
    chk({tag, " frames_skipped"}, fskip, exp_skip);
    chk({tag, " beats_left"}, exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: begin tready = (bp_i % 4 == 0) || (bp_i % 4 == 3); bp_i++; end
      2: tready = 1'($urandom_range(0, 1));
      default: tready = 1'b1;
    endcase
  end

  // Output monitor: beat order/content, stability under stall, streaming rate.
  initial begin
    int    cyc = 0, last_cyc = 0;
    bit    prev_stall = 1'b0, in_frame = 1'b0;
    beat_t sv, e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_stall = 1'b0;
        in_frame   = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall tvalid", tvalid, 1'b1);
          chk("stall tdata", tdata, sv.data);
          chk("stall tkeep/tlast", {tkeep, tlast}, {sv.keep, sv.last});
          chk("stall tuser", tuser, sv.user);
        end
        if (tvalid && tready) begin
          beat_cnt++;
          chk("beat expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tdata", tdata, e.data);
            chk("tkeep", tkeep, e.keep);
            chk("tlast", tlast, e.last);
            chk("tuser", tuser, e.user);
          end
          if (tput_mode) begin
            if (!in_frame) begin
              if (have_prev) chk("frame gap>=5", (cyc - last_cyc) >= 5, 1'b1);
            end else begin
              chk("beat spacing", cyc - last_cyc, 1);
            end
            if (tlast) have_prev = 1'b1;
          end
          last_cyc = cyc;
          in_frame = !tlast;
        end
        prev_stall = tvalid && !tready;
        sv.data = tdata; sv.keep = tkeep; sv.last = tlast; sv.user = tuser;
      end
    end
  end

  initial begin
    int len, len2, r, snap, t;
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst rd_addr", rd_addr, 0);
    chk("rst commited_rd", crd, 0);
    chk("rst tvalid/tlast/tkeep", {tvalid, tlast, tkeep}, 0);
    chk("rst tdata", tdata, 0);
    chk("rst tuser", tuser, 0);
    chk("rst counters", {fsent, fskip}, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // single frame with start-latency check
    put_rec(20, 8'd3, 8'd5, 64'h1234);
    commit();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("latency tvalid after E3", tvalid, 1'b0);
    @(negedge clk);
    chk("latency tvalid after E4", tvalid, 1'b1);
    wait_done("single");

    // filler frame to park the read pointer at 14
    put_rec(56, 8'd1, 8'd2, {$urandom, $urandom});
    commit();
    wait_done("pad");

    // record straddling the end of the ring
    put_rec(16, 8'd7, 8'd9, {$urandom, $urandom});
    commit();
    @(posedge clk);
    @(negedge clk);
    chk("wrap hdr addr", rd_addr, 4'd14);
    @(negedge clk);
    chk("wrap ts addr", rd_addr, 4'd15);
    @(negedge clk);
    chk("wrap payload addr", rd_addr, 4'd0);
    wait_done("wrap");

    // backpressure 1,0,0,1
    bp_i = 0;
    rdy_mode = 1;
    put_rec(64, 8'd4, 8'd6, {$urandom, $urandom});
    commit();
    wait_done("backpressure");
    rdy_mode = 0;

    // skipped records
    snap = beat_cnt;
    put_rec(0, 8'd1, 8'd1, 64'd0);
    commit();
    wait_done("skip len0");
    put_rec(9601, 8'd1, 8'd1, 64'd0);
    commit();
    wait_done("skip oversize");
    chk("skip beats", beat_cnt, snap);

    // two frames committed together
    have_prev = 1'b0;
    tput_mode = 1'b1;
    put_rec(40, 8'd2, 8'd3, {$urandom, $urandom});
    put_rec(33, 8'd4, 8'd5, {$urandom, $urandom});
    commit();
    wait_done("back-to-back");
    tput_mode = 1'b0;

    // reset on beat 2 of 5
    put_rec(40, 8'd8, 8'd8, {$urandom, $urandom});
    snap = beat_cnt + 2;
    commit();
    t = 0;
    while (beat_cnt < snap && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("reached beat 2", beat_cnt >= snap, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst tvalid/tlast/tkeep", {tvalid, tlast, tkeep}, 0);
    chk("midrst tdata", tdata, 0);
    chk("midrst tuser", tuser, 0);
    chk("midrst rd_addr/rd_ptr", {rd_addr, crd}, 0);
    chk("midrst counters", {fsent, fskip}, 0);
    exp_q.delete();
    wb = 4'd0;
    wr_ptr = '0;
    exp_sent = 0;
    exp_skip = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    snap = beat_cnt;
    repeat (20) @(negedge clk);
    chk("post-reset quiet", beat_cnt, snap);
    chk("post-reset rd_ptr", crd, 0);

    // randomized records with random tready
    rdy_mode = 2;
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(9601, 9700);
      else if (r == 9) len = $urandom_range(1, 40);
      else len = $urandom_range(1, 96);
      put_rec(len, 8'($urandom), 8'($urandom), {$urandom, $urandom});
      if (r == 9) begin
        len2 = $urandom_range(1, 40);
        put_rec(len2, 8'($urandom), 8'($urandom), {$urandom, $urandom});
      end
      commit();
      wait_done("random");
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
